// File: rtl/est_atm_light.sv
// est_atm_light: per-frame atmospheric light from the brightest dark-channel pixel.
// Optional temporal IIR smoothing of the published A: define ATM_IIR_EN.
module est_atm_light #(
  parameter logic [7:0] A_MIN = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic       in_eof,
  output logic [7:0] A_r,
  output logic [7:0] A_g,
  output logic [7:0] A_b,
  output logic       A_valid,
  output logic       A_update,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] dark;
  } s1_t;

  function automatic logic [7:0] min3(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] v);
    return (v < A_MIN) ? A_MIN : v;
  endfunction

`ifdef ATM_IIR_EN
  // a_old + (best - a_old)/8 with floor rounding; always lands in 0..255
  function automatic logic [7:0] iir8(
    input logic [7:0] a_old,
    input logic [7:0] best
  );
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [8:0] sum;
    diff = $signed({1'b0, best}) - $signed({1'b0, a_old});
    step = diff >>> 3;
    sum  = $signed({1'b0, a_old}) + step;
    return sum[7:0];
  endfunction
`endif

  state_t state_q;
  state_t state_d;

  logic px_take;
  logic px_first;
  logic px_last;
  logic px_abort;

  logic s1_v;
  s1_t  s1_q;

  logic [7:0] best_dark;
  logic [7:0] best_r;
  logic [7:0] best_g;
  logic [7:0] best_b;
  logic       pub_q;

  logic [7:0] cand_r;
  logic [7:0] cand_g;
  logic [7:0] cand_b;

  logic [21:0] unused_pix_cnt;

  // frame-tracking state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: sof always (re)starts a frame, eof only ends one in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          state_d = in_eof ? UPDATE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_valid && (in_sof || in_eof)) begin
          state_d = in_eof ? UPDATE : ACTIVE;
        end
      end
      UPDATE: begin
        if (in_valid && in_sof) begin
          state_d = in_eof ? UPDATE : ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pixel qualification: which pixels enter the pipe and with which tags
  always_comb begin
    px_take  = 1'b0;
    px_first = 1'b0;
    px_last  = 1'b0;
    px_abort = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        in_sof: begin
          px_take  = 1'b1;
          px_first = 1'b1;
          px_last  = in_eof;
          px_abort = (state_q == ACTIVE) && !in_eof;
        end
        (!in_sof && state_q == ACTIVE): begin
          px_take = 1'b1;
          px_last = in_eof;
        end
        default: ;
      endcase
    end
  end

  // stage 1: capture the accepted pixel and its dark-channel value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else begin
      s1_v <= px_take;
      if (px_take) begin
        s1_q.first <= px_first;
        s1_q.last  <= px_last;
        s1_q.r     <= in_r;
        s1_q.g     <= in_g;
        s1_q.b     <= in_b;
        s1_q.dark  <= min3(in_r, in_g, in_b);
      end
    end
  end

  // stage 2: running best; strict compare so ties keep the earliest pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_dark <= '0;
      best_r    <= '0;
      best_g    <= '0;
      best_b    <= '0;
      pub_q     <= 1'b0;
    end else begin
      pub_q <= s1_v && s1_q.last;
      if (s1_v && (s1_q.first || s1_q.dark > best_dark)) begin
        best_dark <= s1_q.dark;
        best_r    <= s1_q.r;
        best_g    <= s1_q.g;
        best_b    <= s1_q.b;
      end
    end
  end

  // candidate for the next published A
  always_comb begin
`ifdef ATM_IIR_EN
    if (A_valid) begin
      cand_r = iir8(A_r, best_r);
      cand_g = iir8(A_g, best_g);
      cand_b = iir8(A_b, best_b);
    end else begin
      cand_r = best_r;
      cand_g = best_g;
      cand_b = best_b;
    end
`else
    cand_r = best_r;
    cand_g = best_g;
    cand_b = best_b;
`endif
  end

  // publish: A only moves at frame end, so it never changes mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_r      <= 8'd255;
      A_g      <= 8'd255;
      A_b      <= 8'd255;
      A_valid  <= 1'b0;
      A_update <= 1'b0;
    end else begin
      A_update <= pub_q;
      if (pub_q) begin
        A_r     <= clamp(cand_r);
        A_g     <= clamp(cand_g);
        A_b     <= clamp(cand_b);
        A_valid <= 1'b1;
      end
    end
  end

  // aborted-frame flag, one cycle after the restarting sof
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= px_abort;
    end
  end

  // debug pixel count, read through hierarchy only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unused_pix_cnt <= '0;
    end else if (px_take) begin
      if (px_first) begin
        unused_pix_cnt <= 22'd1;
      end else if (unused_pix_cnt != '1) begin
        unused_pix_cnt <= unused_pix_cnt + 22'd1;
      end
    end
  end

endmodule

// File: tb/tb_est_atm_light.sv
// tb_est_atm_light: scoreboard bench for est_atm_light.
// Expected A pushed at each eof, popped on A_update.
module tb_est_atm_light;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_g = '0;
  logic [7:0] in_b = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  logic [7:0] A_r;
  logic [7:0] A_g;
  logic [7:0] A_b;
  logic       A_valid;
  logic       A_update;
  logic       frame_err;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          err_q[$];
  logic [23:0] fq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [23:0] last_a = 24'hFFFFFF;
  bit          seen_upd = 0;
  logic [23:0] m_a = 24'hFFFFFF;
  bit          m_valid = 0;
  bit          pend_abort = 0;

  est_atm_light #(.A_MIN(8'd16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_eof   (in_eof),
    .A_r      (A_r),
    .A_g      (A_g),
    .A_b      (A_b),
    .A_valid  (A_valid),
    .A_update (A_update),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] min3(input logic [23:0] p);
    logic [7:0] m;
    m = (p[23:16] < p[15:8]) ? p[23:16] : p[15:8];
    return (m < p[7:0]) ? m : p[7:0];
  endfunction

  function automatic logic [7:0] ch_next(input logic [7:0] old,
                                         input logic [7:0] best);
    int v;
    v = best;
`ifdef ATM_IIR_EN
    if (m_valid) v = int'(old) + ((int'(best) - int'(old)) >>> 3);
`endif
    if (v < 16) v = 16;
    return v[7:0];
  endfunction

  // outputs checked away from the active edge
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!rst_n) begin
      last_a   = 24'hFFFFFF;
      seen_upd = 0;
    end else begin
      if (A_update) begin
        if (sb_q.size() == 0) begin
          chk("spurious_update", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("A_rgb", {A_r, A_g, A_b}, e.rgb);
          chk("update_latency", cyc, e.due);
        end
        last_a   = {A_r, A_g, A_b};
        seen_upd = 1;
      end else begin
        chk("A_hold", {A_r, A_g, A_b}, last_a);
      end
      chk("A_valid_level", A_valid, seen_upd);
      if (frame_err) begin
        if (err_q.size() == 0) begin
          chk("spurious_frame_err", 1, 0);
        end else begin
          d = err_q.pop_front();
          chk("frame_err_cycle", cyc, d);
        end
      end
    end
  end

  task automatic drive(input logic [23:0] p, input bit sof, input bit eof);
    in_valid = 1'b1;
    in_r     = p[23:16];
    in_g     = p[15:8];
    in_b     = p[7:0];
    in_sof   = sof;
    in_eof   = eof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit gaps);
    logic [7:0]  bd;
    logic [7:0]  dk;
    logic [23:0] br;
    logic [23:0] p;
    logic [23:0] a;
    bd = '0;
    br = '0;
    for (int i = 0; i < fq.size(); i++) begin
      p  = fq[i];
      dk = min3(p);
      if (i == 0 || dk > bd) begin
        bd = dk;
        br = p;
      end
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle(1);
      drive(p, i == 0, i == fq.size() - 1);
      if (i == 0 && pend_abort) begin
        err_q.push_back(cyc);
        pend_abort = 0;
      end
    end
    a[23:16] = ch_next(m_a[23:16], br[23:16]);
    a[15:8]  = ch_next(m_a[15:8], br[15:8]);
    a[7:0]   = ch_next(m_a[7:0], br[7:0]);
    m_a      = a;
    m_valid  = 1;
    sb_q.push_back('{rgb: a, due: cyc + 2});
  endtask

  task automatic send_partial();
    for (int i = 0; i < fq.size(); i++) begin
      drive(fq[i], i == 0, 1'b0);
      if (i == 0 && pend_abort) begin
        err_q.push_back(cyc);
        pend_abort = 0;
      end
    end
    pend_abort = 1;
  endtask

  initial begin
    int n;
    int budget;

    idle(3);
    chk("rst_A", {A_r, A_g, A_b}, 24'hFFFFFF);
    chk("rst_A_valid", A_valid, 0);
    chk("rst_A_update", A_update, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    idle(2);

    // pixels outside a frame are ignored, eof included
    drive(24'hC8C8C8, 0, 0);
    drive(24'hFAFAFA, 0, 1);
    idle(4);
    chk("idle_no_valid", A_valid, 0);

    fq = '{24'h0A141E, 24'hC8B4BE, 24'hFA5AFF, 24'h050505};
    send_frame(0);
    idle(4);
    chk("first_frame_valid", A_valid, 1);

    fq = '{24'h64786E, 24'h82648C};
    send_frame(0);
    idle(4);

    fq = '{24'h0403C8, 24'h010200};
    send_frame(0);
    idle(4);

    fq = '{24'hFAFAFA, 24'hF0F0F0};
    send_partial();
    idle(2);
    fq = '{24'h32463C, 24'h505A64};
    send_frame(0);
    idle(4);

    // back-to-back frames, one-pixel frames, sof during UPDATE
    fq = '{24'h102030, 24'h908070, 24'h404040};
    send_frame(0);
    fq = '{24'h777777};
    send_frame(0);
    fq = '{24'h0C0D0E};
    send_frame(0);
    fq = '{24'h112233, 24'h445566};
    send_frame(0);
    idle(4);

    for (int f = 0; f < 6; f++) begin
      fq = {};
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) fq.push_back(24'($urandom));
      send_frame(1);
      if ($urandom_range(0, 1) == 0) idle(3);
    end
    idle(4);

    // asynchronous reset in the middle of a frame
    fq = '{24'hE0E0E0, 24'hD0D0D0};
    send_partial();
    pend_abort = 0;
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_A", {A_r, A_g, A_b}, 24'hFFFFFF);
    chk("midrst_A_valid", A_valid, 0);
    m_a     = 24'hFFFFFF;
    m_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(24'hF0F0F0, 0, 0);
    drive(24'hF1F1F1, 0, 1);
    idle(4);
    chk("postrst_A_valid", A_valid, 0);

    fq = '{24'hC8C8C8};
    send_frame(0);
    idle(3);
    fq = '{24'h787878, 24'h101010};
    send_frame(0);
    idle(3);
    fq = '{24'h202020, 24'hFFFFFF};
    send_frame(0);

    budget = 50;
    while ((sb_q.size() != 0 || err_q.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(3);
    chk("sb_drained", sb_q.size(), 0);
    chk("err_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
